// File: rtl/rigel_bram_pkg.sv
// Shared constants and helpers for the 16 Kbit dual-port block-RAM family.
package rigel_bram_pkg;

  localparam int BRAM_BITS_TOTAL = 16384;

  function automatic int bram_addr_w(input int bits);
    return 14 - $clog2(bits);
  endfunction

endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry output buffer that hides the RAM's registered read latency.
module bram_fifo_outbuf
  import rigel_bram_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            capture,
  input  logic [BITS-1:0] cap_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic [1:0]      ob_n,
  output logic            pop
);

  logic [BITS-1:0] slot0_q, slot0_d;
  logic [BITS-1:0] slot1_q, slot1_d;
  logic [1:0]      ob_n_q, ob_n_d;

  assign out_valid = (ob_n_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = slot0_q;
  assign ob_n      = ob_n_q;

  // Apply the pop first so a capture lands in the first slot free after the shift.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    ob_n_d  = ob_n_q;
    if (pop) begin
      slot0_d = slot1_q;
      ob_n_d  = ob_n_d - 2'd1;
    end
    if (capture) begin
      if (ob_n_d == 2'd0) begin
        slot0_d = cap_data;
      end else begin
        slot1_d = cap_data;
      end
      ob_n_d = ob_n_d + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      ob_n_q  <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      ob_n_q  <= ob_n_d;
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Ready/valid FIFO controller driving a dual-port BRAM: port A writes, port B reads.
module bram_fifo_ctrl
  import rigel_bram_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int ADDR_W = bram_addr_w(BITS),
  parameter int DEPTH  = BRAM_BITS_TOTAL / BITS
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [BITS-1:0]   ram_dia,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [BITS-1:0]   ram_dob
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_count_q, ram_count_d;
  logic              inflight_q;
  logic              in_ready_q;
  logic              push, issue, pop;
  logic [1:0]        ob_n;
  logic [1:0]        occ_after;

  assign in_ready = in_ready_q;
  assign push     = in_valid & in_ready_q;

  // A pop this cycle frees a slot, so a read may be issued into it without a bubble.
  assign occ_after = ob_n + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (ram_count_q != '0) && (occ_after < 2'd2);

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr_q;
  assign ram_dia   = in_data;
  assign ram_enb   = issue;
  assign ram_addrb = rd_ptr_q;

  assign count = {1'b0, ram_count_q} + {{(ADDR_W + 1){1'b0}}, inflight_q}
               + {{ADDR_W{1'b0}}, ob_n};

  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ram_count_d = ram_count_q;
    case ({push, issue})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= issue;
      in_ready_q  <= (ram_count_d < DEPTH_C);
    end
  end

  bram_fifo_outbuf #(
    .BITS (BITS)
  ) u_outbuf (
    .CLK       (CLK),
    .reset     (reset),
    .capture   (inflight_q),
    .cap_data  (ram_dob),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ob_n      (ob_n),
    .pop       (pop)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural dual-port RAM alongside.
module tb_bram_fifo_ctrl;

  localparam int BITS   = 8;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              CLK = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [BITS-1:0]   in_data;
  logic              out_valid, out_ready;
  logic [BITS-1:0]   out_data;
  logic [ADDR_W+1:0] count;
  logic              ram_ena, ram_wea, ram_enb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [BITS-1:0]   ram_dia, ram_dob;

  logic [BITS-1:0] mem [0:DEPTH-1];
  logic [BITS-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bram_fifo_ctrl #(
    .BITS (BITS)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  // RAM model: synchronous write on A, registered read on B.
  always @(posedge CLK) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy, collision and data checks away from the active edge.
  always @(negedge CLK) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("count_model", 32'(count), exp_q.size());
      if (ram_ena && ram_wea && ram_enb)
        check("port_collision", {31'd0, ram_addra == ram_addrb}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", 32'd1, 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (count != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_count", 32'(count), 32'd0);
  endtask

  task automatic check_reset_values;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_wea", 32'(ram_wea), 32'd0);
    check("rst_ram_enb", 32'(ram_enb), 32'd0);
    check("rst_addra", 32'(ram_addra), 32'd0);
    check("rst_addrb", 32'(ram_addrb), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int k;
    int cyc;
    logic seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check_reset_values();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Single push of 0xA5: visible in cycle 3 only.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    #1;
    check("c0_wea", 32'(ram_wea), 32'd1);
    check("c0_addra", 32'(ram_addra), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("c1_enb", 32'(ram_enb), 32'd1);
    check("c1_valid", 32'(out_valid), 32'd0);
    check("c1_count", 32'(count), 32'd1);
    tick();
    #1;
    check("c2_valid", 32'(out_valid), 32'd0);
    check("c2_count", 32'(count), 32'd1);
    tick();
    #1;
    check("c3_valid", 32'(out_valid), 32'd1);
    check("c3_data", 32'(out_data), 32'hA5);
    check("c3_count", 32'(count), 32'd1);
    tick();
    #1;
    check("c4_valid", 32'(out_valid), 32'd0);
    check("c4_count", 32'(count), 32'd0);

    // Stream 0..99 at full rate.
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'(i);
      #1;
      check("stream_ready", 32'(in_ready), 32'd1);
      if (i >= 3) check("stream_no_bubble", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    wait_empty(20);

    // Fill with output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepted  = 0;
    for (int c = 0; c < 3000; c++) begin
      in_data = 8'(c * 3);
      #1;
      if (!in_ready) break;
      accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("full_accepted", accepted, DEPTH + 2);
    check("full_count", 32'(count), DEPTH + 2);
    tick();
    check("full_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (in_ready) seen = 1'b1;
      if (!seen) tick();
    end
    check("full_recover", 32'(seen), 32'd1);
    out_ready = 1'b1;
    wait_empty(3000);

    // Pointer wrap: 3*DEPTH words with random back-pressure.
    k   = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (k < 3 * DEPTH && cyc < 30000) begin
      in_data   = 8'(k + (k >> 8));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) k++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("wrap_pushes", k, 3 * DEPTH);
    wait_empty(3000);

    // Reset mid-stream with 5 entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("held_count", 32'(count), 32'd5);
    reset = 1'b1;
    #1;
    check_reset_values();
    tick();
    reset = 1'b0;
    tick();
    check("ready_after_midreset", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("post_reset_valid", 32'(out_valid), 32'd1);
    check("post_reset_data", 32'(out_data), 32'h3C);
    tick();
    check("post_reset_empty", 32'(count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty(3000);
    tick();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
